ram_pipe: RTL and testbench
===========================

Name: ram_pipe

Overview:
Parametrised single-port synchronous RAM, the successor to the basic ram block. Adds byte-write enables, a valid/ready request handshake, configurable read latency, and post-reset memory clearing. Serves as CPU scratch/register storage and as a FIFO backing store; one request is accepted per cycle when ready.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from request accept to o_done/o_data, range 1..4.
CLEAR_ON_RESET, 1, 1 = walk memory writing zeros after reset; 0 = skip clearing, ready immediately.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_req  in  1  request valid.
i_we  in  1  1 = write, 0 = read; sampled with i_req.
i_address  in  ADDR_WIDTH  word address.
i_be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
i_data  in  DATA_WIDTH  write data.
o_ready  out  1  block can accept a request this cycle.
o_done  out  1  one-cycle completion pulse, in request order.
o_data  out  DATA_WIDTH  read data; valid when o_done is high for a read.
o_busy_init  out  1  high while the clear walk runs.

Behaviour:
- Reset (async, i_rst=1): o_ready=0, o_done=0, o_data=0, o_busy_init=0; latency pipeline valid bits cleared; FSM to INIT (CLEAR_ON_RESET=1) or RUN (=0). Memory contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT: one word zeroed per cycle, addresses 0 to 2**ADDR_WIDTH-1; o_busy_init=1, o_ready=0. Takes exactly 2**ADDR_WIDTH cycles after reset deasserts; then RUN.
  - RUN: o_ready=1 constantly (no back-pressure).
- Accept = i_req & o_ready. Requests with o_ready=0 are dropped, with no side effects.
- Write accept: for each byte b with i_be[b]=1, mem[addr][8b+7:8b] <= i_data byte b at the accept edge; other bytes unchanged. i_be=0 still completes (o_done pulses) with no memory change.
- Read accept: memory is read at the accept edge, then delayed READ_LATENCY-1 further register stages.
- o_done: pulses exactly READ_LATENCY cycles after accept, for both reads and writes. Back-to-back accepts give back-to-back pulses.
- o_data: updates only on read completions; holds its last read value across write completions and idle cycles.
- Read immediately after write to the same address (next cycle) returns the new data; there are no hazards because the write commits at accept.
- Address wrap: the address is ADDR_WIDTH bits, with no out-of-range case.
- Reset mid-operation: in-flight completions are discarded (no o_done pulse). Any INIT walk restarts from address 0.

Optional Feature:
Macro RAM_PIPE_PARITY_EN.
- Defined: one even-parity bit per byte is stored alongside the data and computed from the final merged byte on write. INIT writes zeros with parity 0. On read completion, output o_parity_err (DATA_WIDTH/8 bits, one per byte) flags mismatching bytes; it is valid with o_done and resets to 0.
- Not defined: no parity storage and no o_parity_err port.

Decomposition:
- Package ram_pkg: FSM state enum (INIT, RUN), function for byte-enable width (DATA_WIDTH/8), constant MAX_READ_LATENCY=4.
- Sub-module ram_lat_pipe: parametrised delay line carrying {valid, is_read, data[, parity_err]} through READ_LATENCY-1 stages, asynchronously reset valid bits. The top level holds the memory array, FSM and byte-merge logic.

Test Plan:
- Reset then idle, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> o_ready=0 and o_busy_init=1 for exactly 16 cycles, then o_ready=1; reading all 16 addresses returns 0x00.
- Write 0xA5 to addr 3 (i_be=1), read addr 3, READ_LATENCY=3 -> two o_done pulses at accept+3 and accept+4; second carries o_data=0xA5.
- DATA_WIDTH=16: write 0x1234 to addr 5, then write 0xFFFF with i_be=2'b10, read -> o_data=0xFF34.
- Back-to-back reads of addrs 0..7 preloaded with addr*0x11, READ_LATENCY=2 -> 8 consecutive o_done pulses with data 0x00,0x11,...,0x77 in order.
- i_req held high during INIT with write 0xEE to addr 0 -> dropped; after INIT, read addr 0 returns 0x00.
- Assert i_rst while 2 reads are in flight -> no o_done pulse, o_data=0, INIT restarts from addr 0. With RAM_PIPE_PARITY_EN, corrupt a stored bit via backdoor -> o_parity_err bit set on that read.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_pipe RAM block.
// Optional parity storage is enabled by defining RAM_PIPE_PARITY_EN.
package ram_pkg;

    // Controller states: clear walk after reset, then normal operation
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Deepest supported read latency (accept to completion, in cycles)
    localparam int MAX_READ_LATENCY = 4;

    // Number of byte lanes in a word
    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Even parity bit for one byte: makes the total number of ones even
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_lat_pipe.sv
// Delay line for completions: carries {valid, is_read, payload} through
// STAGES register stages. Valid/type bits are reset; payload is not.
module ram_lat_pipe #(
    parameter int STAGES    = 0,
    parameter int PAYLOAD_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_is_read,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    output logic                 o_is_read,
    output logic [PAYLOAD_W-1:0] o_payload
);

    generate
        if (STAGES == 0) begin : g_bypass
            // No extra stages: the caller's output register is the only stage
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_valid   = i_valid;
            assign o_is_read = i_is_read;
            assign o_payload = i_payload;
        end else begin : g_stages
            logic [STAGES-1:0]    r_valid;
            logic [STAGES-1:0]    r_is_read;
            logic [PAYLOAD_W-1:0] r_payload [STAGES];

            // Shift control bits; reset drops every in-flight completion
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid   <= '0;
                    r_is_read <= '0;
                end else begin
                    r_valid[0]   <= i_valid;
                    r_is_read[0] <= i_is_read;
                    for (int s = 1; s < STAGES; s++) begin
                        r_valid[s]   <= r_valid[s-1];
                        r_is_read[s] <= r_is_read[s-1];
                    end
                end
            end

            // Shift payload alongside the control bits
            always_ff @(posedge i_clk) begin
                r_payload[0] <= i_payload;
                for (int s = 1; s < STAGES; s++) begin
                    r_payload[s] <= r_payload[s-1];
                end
            end

            assign o_valid   = r_valid[STAGES-1];
            assign o_is_read = r_is_read[STAGES-1];
            assign o_payload = r_payload[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ram_pipe.sv
// Single-port synchronous RAM with byte enables, valid/ready requests,
// configurable read latency and an optional zeroing walk after reset.
// Define RAM_PIPE_PARITY_EN to store per-byte even parity and report
// mismatches on read completions through o_parity_err.
module ram_pipe
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req,
    input  logic                            i_we,
    input  logic [ADDR_WIDTH-1:0]           i_address,
    input  logic [be_width(DATA_WIDTH)-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_ready,
    output logic                            o_done,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic                            o_busy_init
`ifdef RAM_PIPE_PARITY_EN
    ,
    output logic [be_width(DATA_WIDTH)-1:0] o_parity_err
`endif
);

    localparam int BE_W  = be_width(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // Out-of-range latencies are clamped to 1..MAX_READ_LATENCY
    localparam int PIPE_STAGES = (READ_LATENCY > MAX_READ_LATENCY) ? (MAX_READ_LATENCY - 1) :
                                 (READ_LATENCY < 1) ? 0 : (READ_LATENCY - 1);
`ifdef RAM_PIPE_PARITY_EN
    localparam int PAYLOAD_W = DATA_WIDTH + BE_W;
`else
    localparam int PAYLOAD_W = DATA_WIDTH;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_addr;
    logic                    w_ready;
    logic                    w_busy;
    logic                    w_accept;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [DATA_WIDTH-1:0]   w_merged;

    logic [PAYLOAD_W-1:0]    w_pipe_in;
    logic                    w_pipe_valid;
    logic                    w_pipe_is_read;
    logic [PAYLOAD_W-1:0]    w_pipe_out;

    logic                    r_done;
    logic [DATA_WIDTH-1:0]   r_data;

`ifdef RAM_PIPE_PARITY_EN
    logic [BE_W-1:0]         r_par [DEPTH];
    logic [BE_W-1:0]         w_wr_par;
    logic [BE_W-1:0]         w_rd_err;
    logic [BE_W-1:0]         r_parity_err;
`endif

    // State register: a clearing build starts in the walk, otherwise runs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: leave the walk once the last address is zeroed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT: begin
                if (r_init_addr == LAST_ADDR) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = INIT;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    // State outputs; both held low while reset is asserted
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            INIT:    w_busy  = ~i_rst;
            RUN:     w_ready = ~i_rst;
            default: begin
                w_ready = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    // Clear-walk address; restarts from zero on every reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_init_addr <= '0;
        end else if (r_state == INIT) begin
            r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
        end else begin
            r_init_addr <= r_init_addr;
        end
    end

    assign w_accept  = i_req & w_ready;
    assign w_rd_word = r_mem[i_address];

    // Byte merge: enabled lanes take new data, the rest keep stored data
    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < BE_W; b++) begin
            if (i_be[b]) begin
                w_merged[8*b +: 8] = i_data[8*b +: 8];
            end else begin
                w_merged[8*b +: 8] = w_rd_word[8*b +: 8];
            end
        end
    end

`ifdef RAM_PIPE_PARITY_EN
    // Parity of the merged write word and check of the word being read
    always_comb begin
        w_wr_par = '0;
        w_rd_err = '0;
        for (int b = 0; b < BE_W; b++) begin
            w_wr_par[b] = byte_parity(w_merged[8*b +: 8]);
            w_rd_err[b] = byte_parity(w_rd_word[8*b +: 8]) ^ r_par[i_address][b];
        end
    end
`endif

    // Memory write port: the clear walk has priority over requests
    always_ff @(posedge i_clk) begin
        if (r_state == INIT) begin
            r_mem[r_init_addr] <= '0;
`ifdef RAM_PIPE_PARITY_EN
            r_par[r_init_addr] <= '0;
`endif
        end else if (w_accept && i_we) begin
            r_mem[i_address] <= w_merged;
`ifdef RAM_PIPE_PARITY_EN
            r_par[i_address] <= w_wr_par;
`endif
        end
    end

`ifdef RAM_PIPE_PARITY_EN
    assign w_pipe_in = {w_rd_err, w_rd_word};
`else
    assign w_pipe_in = w_rd_word;
`endif

    ram_lat_pipe #(
        .STAGES    (PIPE_STAGES),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_lat_pipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (w_accept),
        .i_is_read (~i_we),
        .i_payload (w_pipe_in),
        .o_valid   (w_pipe_valid),
        .o_is_read (w_pipe_is_read),
        .o_payload (w_pipe_out)
    );

    // Completion register: pulse done, update read data only on reads
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done <= 1'b0;
            r_data <= '0;
        end else begin
            r_done <= w_pipe_valid;
            if (w_pipe_valid && w_pipe_is_read) begin
                r_data <= w_pipe_out[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef RAM_PIPE_PARITY_EN
    // Parity error flags accompany read completions, zero otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_parity_err <= '0;
        end else if (w_pipe_valid && w_pipe_is_read) begin
            r_parity_err <= w_pipe_out[PAYLOAD_W-1:DATA_WIDTH];
        end else begin
            r_parity_err <= '0;
        end
    end

    assign o_parity_err = r_parity_err;
`endif

    assign o_ready     = w_ready;
    assign o_busy_init = w_busy;
    assign o_done      = r_done;
    assign o_data      = r_data;

endmodule

// File: tb/tb_ram_pipe.sv
// Directed testbench for ram_pipe: 16-bit words, 16 entries, read latency 3,
// clearing enabled. Parity checks are added when RAM_PIPE_PARITY_EN is set.
module tb_ram_pipe;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int RL  = 3;
    localparam int BEW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [BEW-1:0] be;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          busy;
`ifdef RAM_PIPE_PARITY_EN
    logic [BEW-1:0] perr;
`endif

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;
    int            dcyc_q [$];
    logic [DW-1:0] ddat_q [$];
`ifdef RAM_PIPE_PARITY_EN
    logic [BEW-1:0] dperr_q [$];
`endif

    always #5 clk = ~clk;

    ram_pipe #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_we        (we),
        .i_address   (addr),
        .i_be        (be),
        .i_data      (wdata),
        .o_ready     (ready),
        .o_done      (done),
        .o_data      (rdata),
        .o_busy_init (busy)
`ifdef RAM_PIPE_PARITY_EN
        ,
        .o_parity_err (perr)
`endif
    );

    // Cycle index advances at each falling edge; completions logged there
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (done === 1'b1) begin
            dcyc_q.push_back(ncyc);
            ddat_q.push_back(rdata);
`ifdef RAM_PIPE_PARITY_EN
            dperr_q.push_back(perr);
`endif
        end
    end

    task automatic clear_q();
        dcyc_q.delete();
        ddat_q.delete();
`ifdef RAM_PIPE_PARITY_EN
        dperr_q.delete();
`endif
    endtask

    // Hold a request for one cycle; returns the cycle its completion is due
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [BEW-1:0] b,
                         input logic [DW-1:0] d, output int exp_c);
        @(posedge clk);
        #1;
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        exp_c = ncyc + 1 + RL;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        int n;
        bit fin;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0; fin = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (ready === 1'b1) fin = 1'b1;
            else if (busy === 1'b1) n++;
        end
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL init_timeout: ready never rose (got %b expected 1)", fin); end
        checks++; if (n != 16) begin errors++; $display("FAIL init_len: got %0d busy cycles expected 16", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_write_read();
        int c0, c1;
        clear_q();
        issue(1'b1, 4'd3, 2'b01, 16'h00A5, c0);
        issue(1'b0, 4'd3, 2'b00, 16'h0000, c1);
        idle(RL + 3);
        checks++;
        if (dcyc_q.size() != 2) begin errors++; $display("FAIL wr_rd_count: got %0d pulses expected 2", dcyc_q.size()); end
        else begin
            checks++; if (dcyc_q[0] != c0) begin errors++; $display("FAIL wr_done_cyc: got %0d expected %0d", dcyc_q[0], c0); end
            checks++; if (dcyc_q[1] != c1) begin errors++; $display("FAIL rd_done_cyc: got %0d expected %0d", dcyc_q[1], c1); end
            checks++; if (ddat_q[0] !== 16'h0000) begin errors++; $display("FAIL wr_hold_data: got %h expected 0000", ddat_q[0]); end
            checks++; if (ddat_q[1] !== 16'h00A5) begin errors++; $display("FAIL rd_data: got %h expected 00a5", ddat_q[1]); end
        end
    endtask

    task automatic test_byte_merge();
        int c [5];
        clear_q();
        issue(1'b1, 4'd5, 2'b11, 16'h1234, c[0]);
        issue(1'b1, 4'd5, 2'b10, 16'hFFFF, c[1]);
        issue(1'b0, 4'd5, 2'b00, 16'h0000, c[2]);
        issue(1'b1, 4'd5, 2'b00, 16'hABCD, c[3]);
        issue(1'b0, 4'd5, 2'b11, 16'h0000, c[4]);
        idle(RL + 3);
        checks++;
        if (dcyc_q.size() != 5) begin errors++; $display("FAIL merge_count: got %0d pulses expected 5", dcyc_q.size()); end
        else begin
            checks++; if (ddat_q[0] !== 16'h00A5) begin errors++; $display("FAIL merge_hold0: got %h expected 00a5", ddat_q[0]); end
            checks++; if (ddat_q[2] !== 16'hFF34) begin errors++; $display("FAIL merge_be10: got %h expected ff34", ddat_q[2]); end
            checks++; if (ddat_q[3] !== 16'hFF34) begin errors++; $display("FAIL merge_hold3: got %h expected ff34", ddat_q[3]); end
            checks++; if (ddat_q[4] !== 16'hFF34) begin errors++; $display("FAIL merge_be00: got %h expected ff34", ddat_q[4]); end
            checks++; if (dcyc_q[3] != c[3]) begin errors++; $display("FAIL merge_be00_done: got %0d expected %0d", dcyc_q[3], c[3]); end
        end
    endtask

    task automatic test_back_to_back();
        int ec [16];
        logic [DW-1:0] v;
        clear_q();
        for (int i = 0; i < 8; i++) begin
            v = 16'(i * 32'h1111);
            issue(1'b1, AW'(i), 2'b11, v, ec[i]);
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, AW'(i), 2'b00, 16'h0000, ec[8+i]);
        end
        idle(RL + 3);
        checks++;
        if (dcyc_q.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 16", dcyc_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (dcyc_q[i] != ec[i]) begin errors++; $display("FAIL b2b_cyc[%0d]: got %0d expected %0d", i, dcyc_q[i], ec[i]); end
            end
            for (int i = 0; i < 8; i++) begin
                v = 16'(i * 32'h1111);
                checks++;
                if (ddat_q[8+i] !== v) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, ddat_q[8+i], v); end
            end
        end
    endtask

    task automatic test_reset_inflight();
        int c0, c1, n;
        bit fin;
        clear_q();
        issue(1'b0, 4'd1, 2'b00, 16'h0000, c0);
        issue(1'b0, 4'd2, 2'b00, 16'h0000, c1);
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL inflight_done: got %b expected 0", done); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL inflight_data: got %h expected 0000", rdata); end
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0; fin = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (ready === 1'b1) fin = 1'b1;
            else if (busy === 1'b1) n++;
        end
        checks++; if (n != 16 || fin !== 1'b1) begin errors++; $display("FAIL reinit_len: got %0d busy cycles (ready %b) expected 16", n, fin); end
        checks++; if (dcyc_q.size() != 0) begin errors++; $display("FAIL inflight_dropped: got %0d pulses expected 0", dcyc_q.size()); end
    endtask

    task automatic test_clear();
        int ec [16];
        clear_q();
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, AW'(i), 2'b00, 16'h0000, ec[i]);
        end
        idle(RL + 3);
        checks++;
        if (dcyc_q.size() != 16) begin errors++; $display("FAIL clear_count: got %0d pulses expected 16", dcyc_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (ddat_q[i] !== 16'h0000 || dcyc_q[i] != ec[i]) begin
                    errors++;
                    $display("FAIL clear_word[%0d]: got %h at cycle %0d expected 0000 at %0d", i, ddat_q[i], dcyc_q[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_init_drop();
        int c0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b1; we = 1'b1; addr = 4'd0; be = 2'b11; wdata = 16'h00EE;
        clear_q();
        repeat (16) @(posedge clk);
        #1 req = 1'b0;
        we = 1'b0;
        repeat (RL + 2) @(posedge clk);
        checks++; if (dcyc_q.size() != 0) begin errors++; $display("FAIL init_drop_done: got %0d pulses expected 0", dcyc_q.size()); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_drop_ready: got %b expected 1", ready); end
        issue(1'b0, 4'd0, 2'b00, 16'h0000, c0);
        idle(RL + 3);
        checks++;
        if (dcyc_q.size() != 1) begin errors++; $display("FAIL init_drop_rd_count: got %0d pulses expected 1", dcyc_q.size()); end
        else begin
            checks++; if (ddat_q[0] !== 16'h0000) begin errors++; $display("FAIL init_drop_data: got %h expected 0000", ddat_q[0]); end
        end
    endtask

`ifdef RAM_PIPE_PARITY_EN
    task automatic test_parity();
        int c0, c1, c2;
        clear_q();
        issue(1'b1, 4'd9, 2'b11, 16'h3C3C, c0);
        idle(RL + 2);
        @(posedge clk);
        #1 dut.r_mem[9] = dut.r_mem[9] ^ 16'h0100;
        clear_q();
        issue(1'b0, 4'd9, 2'b00, 16'h0000, c1);
        issue(1'b0, 4'd10, 2'b00, 16'h0000, c2);
        idle(RL + 3);
        checks++;
        if (dcyc_q.size() != 2) begin errors++; $display("FAIL parity_count: got %0d pulses expected 2", dcyc_q.size()); end
        else begin
            checks++; if (dperr_q[0] !== 2'b10) begin errors++; $display("FAIL parity_flag: got %b expected 10", dperr_q[0]); end
            checks++; if (ddat_q[0] !== 16'h3D3C) begin errors++; $display("FAIL parity_data: got %h expected 3d3c", ddat_q[0]); end
            checks++; if (dperr_q[1] !== 2'b00) begin errors++; $display("FAIL parity_clean: got %b expected 00", dperr_q[1]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_merge();
        test_back_to_back();
        test_reset_inflight();
        test_clear();
        test_init_drop();
`ifdef RAM_PIPE_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
